mux_n_rr: RTL and testbench
===========================

Name: mux_n_rr

Overview:
Parametrised N-to-1 registered multiplexer with a per-channel valid/ready handshake. It generalises the 2:1 combinational mux in three ways: any channel count, any data width, and two selection modes (fixed select or round-robin arbitration). The output is registered and sustains one transfer per cycle. It sits between multiple producer streams and a single consumer stream in the datapath.

Parameters:
- WIDTH, 8: data width of every channel in bits (>=1).
- NCH, 4: number of input channels (>=2; non-power-of-two allowed).
- SELW, $clog2(NCH): derived localparam giving the select and channel-ID width. Not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  selection mode: 0 = fixed select via sel, 1 = round-robin.
- sel  input  SELW  channel select, used only when mode=0.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- out_data  output  WIDTH  registered output data.
- out_ch  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last=NCH-1, so channel 0 has first priority after reset.
  - in_ready is all 0 while rst=1.
- Load enable: ld = !out_valid || out_ready. This gives full throughput with a single register stage and no skid buffer.
- Grant, mode=0:
  - gnt = sel if sel<NCH and in_valid[sel]=1.
  - Otherwise there is no grant: sel>=NCH always produces no grant, and valid on other channels is ignored.
- Grant, mode=1:
  - Scan channels last+1, last+2, ... wrapping modulo NCH, ending at last.
  - The first channel with in_valid=1 wins.
  - If no channel is valid, there is no grant.
- in_ready[i] = ld && (a grant exists) && (i == gnt). At most one bit is set per cycle. in_ready is not a function of in_valid of other channels except through the grant.
- Transfer in: occurs when a grant exists and ld=1. On the next edge: out_data <= in_data[gnt], out_ch <= gnt, out_valid <= 1.
- Pointer update: last <= gnt on every input transfer, in either mode. This keeps round-robin fair across mode switches.
- No grant and ld=1: out_valid <= 0 on the next edge. out_data and out_ch hold their previous values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid are held stable, and in_ready is all 0.
- Latency: exactly 1 cycle from an input handshake to out_valid.
- Simultaneous output drain and new grant (out_valid=1, out_ready=1, grant): the register is replaced in the same edge with no bubble.
- Changes to mode or sel affect only the current cycle's grant. They never alter a held output.
- Reset asserted mid-transfer: held data is discarded and outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: MUX_N_RR_XFER_CNT_EN.
- Defined:
  - Adds port xfer_cnt, output, 16 bits: a count of completed output handshakes (out_valid && out_ready).
  - Increments once per handshake and saturates at 16'hFFFF (no wrap).
  - Async reset to 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan (WIDTH=8, NCH=4):
- Reset: assert rst with in_valid=4'hF, then deassert → out_valid=0, out_data=0, out_ch=0 and in_ready=0 during reset. The first round-robin grant after reset goes to channel 0.
- Fixed mode:
  - Stimulus: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1.
  - Response: in_ready=4'b0100. Next cycle out_data=8'hA5, out_ch=2, out_valid=1.
  - Then sel=1 with in_valid[1]=0 → no grant; out_valid=0 on the following cycle.
- Round-robin fairness:
  - Stimulus: mode=1, in_valid=4'hF held, out_ready=1, channel i data = 8'h10+i.
  - Response: out_ch sequence 0,1,2,3,0,1 with out_data 10,11,12,13,10,11 on consecutive cycles (full throughput).
- Backpressure:
  - Stimulus: out_valid=1 holding 8'h11, out_ready=0 for 3 cycles.
  - Response: out_data=8'h11 and out_ch held; in_ready=0 throughout.
  - Then out_ready=1 → the next channel is granted the same cycle, with no bubble.
- Sparse round-robin: last=1, in_valid=4'b1001 → grant ch3; next cycle grant ch0; then ch3 again.
- MUX_N_RR_XFER_CNT_EN defined: 5 output handshakes → xfer_cnt=5. Force the counter to 16'hFFFF plus one more handshake → stays 16'hFFFF.

Source files
------------

// File: rtl/mux_n_rr.sv
// mux_n_rr: N-to-1 registered multiplexer with per-channel valid/ready.
// Selection is either a fixed channel select (mode=0) or round-robin
// arbitration (mode=1). One output register stage; the stage reloads whenever
// it is empty or being drained, so the mux sustains one transfer per cycle.
// Optional build macro: MUX_N_RR_XFER_CNT_EN adds a saturating 16-bit count
// of output handshakes on port xfer_cnt.
module mux_n_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_N_RR_XFER_CNT_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;
  logic [SELW-1:0]  r_last;

  logic             w_ld;
  logic             w_fx_vld;
  logic             w_rr_vld;
  logic [SELW-1:0]  w_rr_gnt;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt;
  logic [WIDTH-1:0] w_gnt_data;

  // Output stage may load when empty or when its contents leave this cycle.
  assign w_ld = !r_out_valid || out_ready;

  // Fixed-select grant: only the selected channel counts; out-of-range sel never grants.
  always_comb begin
    w_fx_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if ((int'(sel) == i) && in_valid[i]) w_fx_vld = 1'b1;
    end
  end

  // Round-robin grant: first valid channel scanning from last+1 around to last.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_gnt = '0;
    for (int k = 1; k <= NCH; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!w_rr_vld && in_valid[i] && (i == ((int'(r_last) + k) % NCH))) begin
          w_rr_vld = 1'b1;
          w_rr_gnt = SELW'(i);
        end
      end
    end
  end

  assign w_gnt_vld = mode ? w_rr_vld : w_fx_vld;
  assign w_gnt     = mode ? w_rr_gnt : sel;

  // Select the granted channel's data and raise its ready when the stage can load.
  always_comb begin
    w_gnt_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(w_gnt) == i) begin
        w_gnt_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && w_ld && w_gnt_vld;
      end
    end
  end

  // Output register and round-robin pointer; pointer follows every transfer in either mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_last      <= SELW'(NCH - 1);
    end else if (w_ld) begin
      if (w_gnt_vld) begin
        r_out_data  <= w_gnt_data;
        r_out_ch    <= w_gnt;
        r_out_valid <= 1'b1;
        r_last      <= w_gnt;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

`ifdef MUX_N_RR_XFER_CNT_EN
  logic [15:0] r_xfer_cnt;

  // Count output handshakes, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (r_out_valid && out_ready && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_mux_n_rr.sv
// tb_mux_n_rr: directed self-checking bench for mux_n_rr (WIDTH=8, NCH=4).
module tb_mux_n_rr;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX_N_RR_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_total = 0;
  int n_fail  = 0;

  mux_n_rr #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_N_RR_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] ch, input logic [7:0] data,
                         input logic vld);
    chk({tag, "_ch"},   {30'd0, out_ch}, {30'd0, ch});
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, data});
    chk({tag, "_vld"},  {31'd0, out_valid}, {31'd0, vld});
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset state while all channels request
    #2;
    chk_out("reset", 2'd0, 8'h00, 1'b0);
    chk("reset_in_ready", {28'd0, in_ready}, 32'h0);
`ifdef MUX_N_RR_XFER_CNT_EN
    chk("reset_xfer_cnt", {16'd0, xfer_cnt}, 32'h0);
`endif
    tick;
    tick;
    chk("reset_in_ready_clk", {28'd0, in_ready}, 32'h0);
    chk_out("reset_clk", 2'd0, 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    chk("rr_first_gnt", {28'd0, in_ready}, 32'h1);

    // Round-robin with all channels valid: 0,1,2,3,0,1 back to back
    for (int n = 0; n < 6; n++) begin
      tick;
      chk_out("rr_seq", 2'(n % 4), 8'(8'h10 + n % 4), 1'b1);
    end

    // Backpressure holds 8'h11 from channel 1
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready0", {28'd0, in_ready}, 32'h0);
    for (int n = 0; n < 3; n++) begin
      tick;
      chk_out("bp_hold", 2'd1, 8'h11, 1'b1);
      chk("bp_in_ready", {28'd0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_gnt", {28'd0, in_ready}, 32'h4);
    tick;
    chk_out("bp_release_out", 2'd2, 8'h12, 1'b1);

    // Fixed select on channel 2
    mode     = 1'b0;
    sel      = 2'd2;
    in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
    in_valid = 4'b0100;
    #1;
    chk("fx_in_ready", {28'd0, in_ready}, 32'h4);
    tick;
    chk_out("fx_out", 2'd2, 8'hA5, 1'b1);

    // Selected channel idle: other valid channels are ignored
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1;
    chk("fx_nogrant_rdy", {28'd0, in_ready}, 32'h0);
    tick;
    chk_out("fx_nogrant_out", 2'd2, 8'hA5, 1'b0);

    // Fixed transfer from channel 1 moves the round-robin pointer to 1
    in_valid = 4'b0010;
    in_data  = {8'h13, 8'hA5, 8'h5A, 8'h10};
    #1;
    chk("fx_ch1_rdy", {28'd0, in_ready}, 32'h2);
    tick;
    chk_out("fx_ch1_out", 2'd1, 8'h5A, 1'b1);

    // Sparse round-robin after last=1: 3, 0, 3
    mode     = 1'b1;
    in_valid = 4'b1001;
    #1;
    chk("sp_rdy3", {28'd0, in_ready}, 32'h8);
    tick;
    chk_out("sp_out3", 2'd3, 8'h13, 1'b1);
    chk("sp_rdy0", {28'd0, in_ready}, 32'h1);
    tick;
    chk_out("sp_out0", 2'd0, 8'h10, 1'b1);
    chk("sp_rdy3b", {28'd0, in_ready}, 32'h8);
    tick;
    chk_out("sp_out3b", 2'd3, 8'h13, 1'b1);

    // Reset while an output is held: clears without a clock edge
    out_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 2'd0, 8'h00, 1'b0);
    chk("async_rst_rdy", {28'd0, in_ready}, 32'h0);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", {28'd0, in_ready}, 32'h1);

`ifdef MUX_N_RR_XFER_CNT_EN
    // Six loads, the last five of which drain a valid output
    for (int n = 0; n < 6; n++) tick;
    chk("xfer_cnt5", {16'd0, xfer_cnt}, 32'd5);
    force dut.r_xfer_cnt = 16'hFFFF;
    #1;
    release dut.r_xfer_cnt;
    tick;
    chk("xfer_cnt_sat", {16'd0, xfer_cnt}, 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
